// File: rtl/reg_access_if.sv
// Request/response and register-bank bus of the SD host register access master.
// Ports: req_* (host request), rsp_* (response), reg_* (register bank side).
interface reg_access_if #(
  parameter int WIDTH  = 32,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_W-1:0]       req_addr;
  logic [WIDTH-1:0]        req_wdata;
  logic                    rsp_valid;
  logic [WIDTH-1:0]        rsp_rdata;
  logic                    rsp_err;
  logic [NREG-1:0]         reg_wr_valid;
  logic [WIDTH-1:0]        reg_wr_data;
  logic [NREG*WIDTH-1:0]   reg_rd_data;
  logic [NREG-1:0]         reg_ack;
  logic [NREG-1:0]         reg_busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  reg_rd_data, reg_ack, reg_busy,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output reg_wr_valid, reg_wr_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output reg_rd_data, reg_ack, reg_busy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  reg_wr_valid, reg_wr_data
  );
endinterface

// File: rtl/reg_access_master.sv
// Initiator of the register write/read handshake toward NREG register blocks.
// Ports: clk, reset (sync, active-low), bus (reg_access_if.master).
module reg_access_master #(
  parameter int WIDTH   = 32,
  parameter int NREG    = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  reg_access_if.master  bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  LP_CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   LP_NREG    = (ADDR_W + 1)'(NREG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FREE,
    S_WRITE,
    S_WAIT_ACK,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic                r_bad;
  logic [WIDTH-1:0]    r_wdata;
  logic [WIDTH-1:0]    r_rdata;
  logic                r_err;
  logic [WIDTH-1:0]    r_wr_data;

  logic                w_ready;
  logic                w_accept;
  logic                w_busy;
  logic                w_ack;
  logic [WIDTH-1:0]    w_rd_sel;
  logic [NREG-1:0]     w_onehot;
  logic                w_rsp_load;
  logic                w_err_nxt;
  logic [WIDTH-1:0]    w_rdata_nxt;
  logic                w_enter_write;

  assign w_ready  = reset && (r_state == S_IDLE);
  assign w_accept = bus.req_valid && w_ready;

  // Per-index select of busy/ack/rdata; an out-of-range
  // address never matches, so nothing outside NREG is read.
  always_comb begin
    w_busy   = 1'b0;
    w_ack    = 1'b0;
    w_rd_sel = '0;
    w_onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      if (r_addr == ADDR_W'(i)) begin
        w_busy      = bus.reg_busy[i];
        w_ack       = bus.reg_ack[i];
        w_rd_sel    = bus.reg_rd_data[i*WIDTH +: WIDTH];
        w_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_cnt_nxt     = r_cnt;
    w_rsp_load    = 1'b0;
    w_err_nxt     = 1'b0;
    w_rdata_nxt   = '0;
    w_enter_write = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next    = S_WAIT_FREE;
          w_cnt_nxt = '0;
        end
      end
      S_WAIT_FREE: begin
        // A bad address spends this one decode cycle
        // before answering, so its response lands at c2.
        if (r_bad) begin
          w_next     = S_RESP;
          w_rsp_load = 1'b1;
          w_err_nxt  = 1'b1;
        end else if (!w_busy) begin
          w_cnt_nxt = '0;
          if (r_write) begin
            w_next        = S_WRITE;
            w_enter_write = 1'b1;
          end else begin
            w_next = S_WAIT_ACK;
          end
        end else if (r_cnt == LP_CNT_MAX) begin
          w_next     = S_RESP;
          w_rsp_load = 1'b1;
          w_err_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WRITE: begin
        w_cnt_nxt = '0;
        w_next    = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (w_ack) begin
          w_next      = S_RESP;
          w_rsp_load  = 1'b1;
          w_rdata_nxt = r_write ? '0 : w_rd_sel;
        end else if (r_cnt == LP_CNT_MAX) begin
          w_next     = S_RESP;
          w_rsp_load = 1'b1;
          w_err_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_bad     <= 1'b0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= bus.req_addr;
        r_write <= bus.req_write;
        r_wdata <= bus.req_wdata;
        r_bad   <= {1'b0, bus.req_addr} >= LP_NREG;
      end
      if (w_enter_write) begin
        r_wr_data <= r_wdata;
      end
      if (w_rsp_load) begin
        r_rdata <= w_rdata_nxt;
        r_err   <= w_err_nxt;
      end
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.rsp_valid    = (r_state == S_RESP);
  assign bus.rsp_rdata    = r_rdata;
  assign bus.rsp_err      = r_err;
  assign bus.reg_wr_data  = r_wr_data;
  assign bus.reg_wr_valid = (r_state == S_WRITE) ? w_onehot : '0;

endmodule

// File: tb/tb_reg_access_master.sv
// Directed bench for reg_access_master (NREG=6, TIMEOUT=16).
// Expected responses are queued at issue and popped at rsp_valid.
module tb_reg_access_master;

  localparam int W  = 32;
  localparam int N  = 6;
  localparam int AW = 3;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_access_if #(.WIDTH(W), .NREG(N), .ADDR_W(AW)) bus ();

  reg_access_master #(
    .WIDTH(W), .NREG(N), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int            lat;
    logic          err;
    logic [W-1:0]  rd;
    int            pk;
    logic [N-1:0]  pv;
    logic [W-1:0]  pd;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int waited;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input int lat,
                        input logic err, input logic [W-1:0] rd,
                        input int pk, input int bdrop,
                        output int wt);
    exp_t e;
    exp_t g;
    int   npulse;
    logic got;
    logic [N-1:0] one;
    one      = '0;
    one[0]   = 1'b1;
    e.lat = lat;
    e.err = err;
    e.rd  = rd;
    e.pk  = pk;
    e.pv  = (pk > 0) ? (one << a) : '0;
    e.pd  = (pk > 0) ? d : '0;
    sb.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    wt = 0;
    while (!bus.req_ready && wt < 40) begin
      @(negedge clk);
      wt++;
    end
    g.lat = 0; g.err = 1'b0; g.rd = '0;
    g.pk = 0; g.pv = '0; g.pd = '0;
    npulse = 0;
    got = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.reg_wr_valid !== '0) begin
        npulse++;
        g.pk = k;
        g.pv = bus.reg_wr_valid;
        g.pd = bus.reg_wr_data;
      end
      if (bdrop > 0 && k == bdrop) bus.reg_busy = '0;
      if (bus.rsp_valid === 1'b1) begin
        got   = 1'b1;
        g.lat = k;
        g.err = bus.rsp_err;
        g.rd  = bus.rsp_rdata;
        break;
      end
    end
    bus.req_valid = 1'b0;
    e = sb.pop_front();
    chk("rsp_seen", got, 1'b1);
    chk("latency", g.lat, e.lat);
    chk("rsp_err", g.err, e.err);
    chk("rsp_rdata", g.rd, e.rd);
    chk("wr_pulses", npulse, (e.pk > 0) ? 1 : 0);
    chk("wr_pulse_cycle", g.pk, e.pk);
    chk("wr_valid", g.pv, e.pv);
    chk("wr_data", g.pd, e.pd);
  endtask

  initial begin
    bus.req_valid   = 1'b1;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.reg_ack     = '1;
    bus.reg_busy    = '0;
    bus.reg_rd_data = '0;
    bus.reg_rd_data[0*W +: W] = 32'h55AA55AA;
    bus.reg_rd_data[1*W +: W] = 32'hCAFEF00D;
    bus.reg_rd_data[3*W +: W] = 32'h0BADC0DE;
    bus.reg_rd_data[4*W +: W] = 32'h0F0F1234;
    bus.reg_rd_data[5*W +: W] = 32'h12345678;

    // reset held 3 cycles with req_valid high
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.req_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, '0);
    chk("rst_wr_valid", bus.reg_wr_valid, '0);
    chk("rst_wr_data", bus.reg_wr_data, '0);
    reset = 1'b1;
    bus.req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", bus.req_ready, 1'b1);
      chk("idle_rsp_valid", bus.rsp_valid, 1'b0);
      chk("idle_wr_valid", bus.reg_wr_valid, '0);
    end

    // write addr 2, other indices busy and not acking
    bus.reg_busy = 6'b111011;
    bus.reg_ack  = 6'b000100;
    do_req(1'b1, 3'd2, 32'hDEADBEEF, 4, 1'b0, '0, 2, 0, waited);
    bus.reg_busy = '0;
    bus.reg_ack  = '1;

    // read addr 5, busy for 3 cycles
    bus.reg_busy = 6'b100000;
    do_req(1'b0, 3'd5, 32'h0, 6, 1'b0, 32'h12345678, 0, 4, waited);
    @(negedge clk);
    chk("rdata_hold", bus.rsp_rdata, 32'h12345678);
    chk("wrdata_hold", bus.reg_wr_data, 32'hDEADBEEF);

    // ack timeout on read addr 1
    bus.reg_ack = 6'b111101;
    do_req(1'b0, 3'd1, 32'h0, 2 + TO, 1'b1, '0, 0, 0, waited);
    @(negedge clk);
    chk("to_ready_back", bus.req_ready, 1'b1);
    bus.reg_ack = '1;

    // busy releases exactly on the last counted cycle
    bus.reg_busy = 6'b001000;
    do_req(1'b0, 3'd3, 32'h0, TO + 2, 1'b0, 32'h0BADC0DE, 0, TO, waited);

    // busy never releases on a write
    bus.reg_busy = 6'b000001;
    do_req(1'b1, 3'd0, 32'h11112222, TO + 1, 1'b1, '0, 0, 0, waited);
    bus.reg_busy = '0;
    chk("wrdata_after_to", bus.reg_wr_data, 32'hDEADBEEF);

    // bad address, then back-to-back read
    do_req(1'b1, 3'd7, 32'h33334444, 2, 1'b1, '0, 0, 0, waited);
    do_req(1'b0, 3'd0, 32'h0, 3, 1'b0, 32'h55AA55AA, 0, 0, waited);
    chk("b2b_wait", waited, 1);
    do_req(1'b0, 3'd6, 32'h0, 2, 1'b1, '0, 0, 0, waited);

    // reset during WAIT_ACK of a write
    bus.reg_ack   = '0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 3'd4;
    bus.req_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
    chk("abort_wr_valid", bus.reg_wr_valid, '0);
    chk("abort_ready", bus.req_ready, 1'b0);
    chk("abort_rsp_err", bus.rsp_err, 1'b0);
    reset = 1'b1;
    bus.reg_ack = '1;
    @(negedge clk);
    chk("abort_idle", bus.req_ready, 1'b1);
    chk("abort_no_rsp", bus.rsp_valid, 1'b0);
    do_req(1'b0, 3'd4, 32'h0, 3, 1'b0, 32'h0F0F1234, 0, 0, waited);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
